simon_pattern_input: RTL and testbench

Input conditioner that sits directly upstream of the Simon game controller. It synchronizes the raw pattern switches and the submit push-button, debounces the button, and turns each clean press into a single-cycle `pattern_valid` strobe with a registered `pattern` word. The controller and datapath consume these outputs: `pattern_valid` drives the controller's input/repeat handling, and `pattern` feeds the datapath's memory write and compare. Presses with an illegal switch setting are rejected with a one-cycle `pattern_err` strobe instead.

---
 rtl/simon_pattern_input.sv | 129 ++++++++++++
 tb/tb_simon_pattern_input.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_pattern_input.sv
// Simon input conditioner: 2-flop syncs, button debounce FSM, one strobe per press (SIMON_INPUT_ONEHOT_CHECK_EN: one-hot legality).
// Latency: strobe DEBOUNCE_CYCLES+2 edges after the first sampled press; btn_level falls DEBOUNCE_CYCLES+2 edges after the first sampled release.
// Backpressure: none; strobes are single-cycle and must be consumed when asserted.
module simon_pattern_input #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic             pattern_err,
    output logic             btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_RELEASE_WAIT
    } state_t;

    logic [WIDTH-1:0] r_sw_meta;
    logic [WIDTH-1:0] r_sw_s;
    logic             r_btn_meta;
    logic             r_btn_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_capture;
    logic             w_legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_meta  <= '0;
            r_sw_s     <= '0;
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_sw_meta  <= sw;
            r_sw_s     <= r_sw_meta;
            r_btn_meta <= btn;
            r_btn_s    <= r_btn_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter is zero whenever btn_s agrees with the debounced level.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_PRESS_WAIT: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HELD;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_HELD: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_RELEASE_WAIT: begin
                if (r_btn_s) begin
                    w_state_nxt = S_HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef SIMON_INPUT_ONEHOT_CHECK_EN
    assign w_legal = (r_sw_s != '0) && ((r_sw_s & (r_sw_s - WIDTH'(1))) == '0);
`else
    assign w_legal = |r_sw_s;
`endif

    // Illegal presses still update pattern so the datapath sees what was entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern       <= '0;
            pattern_valid <= 1'b0;
            pattern_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                pattern <= r_sw_s;
            end
            pattern_valid <= w_capture & w_legal;
            pattern_err   <= w_capture & ~w_legal;
        end
    end

    assign btn_level = (r_state == S_HELD) || (r_state == S_RELEASE_WAIT);

endmodule

// File: tb/tb_simon_pattern_input.sv
// Bench for simon_pattern_input with WIDTH=4, DEBOUNCE_CYCLES=4; expected strobes queued at stimulus time.
module tb_simon_pattern_input;

    localparam int W   = 4;
    localparam int D   = 4;
    localparam int LAT = D + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] sw  = '0;
    logic         btn = 1'b0;
    logic [W-1:0] pattern;
    logic         pattern_valid;
    logic         pattern_err;
    logic         btn_level;

    typedef struct {
        logic         err;
        logic [W-1:0] pat;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    simon_pattern_input #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .sw            (sw),
        .btn           (btn),
        .pattern       (pattern),
        .pattern_valid (pattern_valid),
        .pattern_err   (pattern_err),
        .btn_level     (btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic legal(input logic [W-1:0] v);
`ifdef SIMON_INPUT_ONEHOT_CHECK_EN
        return $countones(v) == 1;
`else
        return v != '0;
`endif
    endfunction

    // Scoreboard side: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (pattern_valid || pattern_err) begin
            n_checks++;
            if (pattern_valid && pattern_err) begin
                n_fail++;
                $display("FAIL both_strobes cyc=%0d valid=%b err=%b required not both high", cyc, pattern_valid, pattern_err);
            end
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe cyc=%0d valid=%b err=%b pattern=%b required no strobe", cyc, pattern_valid, pattern_err, pattern);
            end else begin
                mon_e = sb.pop_front();
                n_checks++;
                if (pattern_err !== mon_e.err) begin
                    n_fail++;
                    $display("FAIL strobe_kind cyc=%0d err=%b required err=%b", cyc, pattern_err, mon_e.err);
                end
                n_checks++;
                if (pattern !== mon_e.pat) begin
                    n_fail++;
                    $display("FAIL strobe_pattern cyc=%0d pattern=%b required %b", cyc, pattern, mon_e.pat);
                end
                n_checks++;
                if (cyc !== mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL strobe_time strobe at cyc=%0d required cyc=%0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic press(input logic [W-1:0] v, input bit expect_strobe);
        exp_t e;
        sw = v;
        if (expect_strobe) begin
            e.err = ~legal(v);
            e.pat = v;
            e.cyc = cyc + LAT;
            sb.push_back(e);
        end
        btn = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        btn = 1'b0;
        sw  = 4'b1111;
        idle_cycles(3);
        n_checks++;
        if (pattern !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pattern got=%b required 0000", pattern);
        end
        n_checks++;
        if (pattern_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b required 0", pattern_valid);
        end
        n_checks++;
        if (pattern_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err got=%b required 0", pattern_err);
        end
        n_checks++;
        if (btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_btn_level got=%b required 0", btn_level);
        end
        sw  = '0;
        rst = 1'b1;
        idle_cycles(3);
    endtask

    task automatic test_clean_press;
        int c0;
        press(4'b0100, 1'b1);
        idle_cycles(20);
        n_checks++;
        if (btn_level !== 1'b1) begin
            n_fail++;
            $display("FAIL held_btn_level got=%b required 1", btn_level);
        end
        n_checks++;
        if (pattern !== 4'b0100) begin
            n_fail++;
            $display("FAIL held_pattern got=%b required 0100", pattern);
        end
        btn = 1'b0;
        c0  = cyc;
        idle_cycles(LAT - 1);
        n_checks++;
        if (btn_level !== 1'b1) begin
            n_fail++;
            $display("FAIL release_early btn_level=%b at cyc=%0d required 1", btn_level, cyc - c0);
        end
        idle_cycles(1);
        n_checks++;
        if (btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL release_late btn_level=%b at cyc=%0d required 0", btn_level, cyc - c0);
        end
        idle_cycles(4);
    endtask

    task automatic test_bounce;
        bit seq [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        sw = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) press(4'b0010, 1'b1);
            else btn = seq[i];
            idle_cycles(1);
        end
        idle_cycles(15);
        btn = 1'b0;
        idle_cycles(10);
    endtask

    task automatic test_zero;
        press(4'b0000, 1'b1);
        idle_cycles(10);
        btn = 1'b0;
        idle_cycles(10);
    endtask

    task automatic test_multi_bit;
        press(4'b0110, 1'b1);
        idle_cycles(10);
        btn = 1'b0;
        idle_cycles(10);
    endtask

    task automatic test_short_release;
        press(4'b0001, 1'b1);
        idle_cycles(10);
        btn = 1'b0;
        idle_cycles(3);
        btn = 1'b1;
        sw  = 4'b0010;
        idle_cycles(15);
        n_checks++;
        if (pattern !== 4'b0001) begin
            n_fail++;
            $display("FAIL short_release_pattern got=%b required 0001", pattern);
        end
        btn = 1'b0;
        idle_cycles(8);
        press(4'b1000, 1'b1);
        idle_cycles(12);
        btn = 1'b0;
        idle_cycles(10);
    endtask

    task automatic test_reset_mid;
        press(4'b0100, 1'b0);
        idle_cycles(4);
        rst = 1'b0;
        #1;
        n_checks++;
        if (pattern !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_pattern got=%b required 0000", pattern);
        end
        n_checks++;
        if (pattern_valid !== 1'b0 || pattern_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_strobes valid=%b err=%b required 0 0", pattern_valid, pattern_err);
        end
        n_checks++;
        if (btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_btn_level got=%b required 0", btn_level);
        end
        idle_cycles(2);
        rst = 1'b1;
        press(4'b0100, 1'b1);
        idle_cycles(12);
        n_checks++;
        if (btn_level !== 1'b1) begin
            n_fail++;
            $display("FAIL postrst_btn_level got=%b required 1", btn_level);
        end
        btn = 1'b0;
        idle_cycles(10);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_zero();
        test_multi_bit();
        test_short_release();
        test_reset_mid();
        idle_cycles(10);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_strobes pending=%0d required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
